// File: rtl/riscv_pkg.sv
// Shared types, opcodes and mux encodings for the multicycle RV32I control unit.
package riscv_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
    } operator_t;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
    } inst_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // alt selects SUB/SRA; callers mask it for forms where funct7 is immediate bits
    function automatic operator_t funct3_to_op(input logic [2:0] funct3, input logic alt);
        operator_t op;
        case (funct3)
            3'b000:  op = alt ? SUB : ADD;
            3'b001:  op = SLL;
            3'b010:  op = SLT;
            3'b011:  op = SLTU;
            3'b100:  op = XOR;
            3'b101:  op = alt ? SRA : SRL;
            3'b110:  op = OR;
            default: op = AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decode: instruction class, ALU controls, branch condition, legality.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]  inst,
    input  logic         zeros,
    input  logic         flag_lt,
    input  logic         flag_ltu,
    output operator_t    alu_op,
    output logic         alu_sel_1,
    output logic         alu_sel_2,
    output inst_class_t  inst_class,
    output logic         branch_taken,
    output logic         rd_zero,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign funct7      = inst[31:25];
    assign rd_zero     = (inst[11:7] == 5'd0);
    assign unused_bits = ^inst[24:15];
    assign illegal     = (inst_class == CLS_ILLEGAL);

    always_comb begin
        inst_class = CLS_ILLEGAL;
        alu_op     = ADD;
        alu_sel_1  = 1'b1;
        alu_sel_2  = 1'b1;
        case (opcode)
            OPC_R: begin
                alu_op = funct3_to_op(funct3, funct7[5]);
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    inst_class = CLS_R;
            end
            OPC_OPIMM: begin
                alu_sel_2 = 1'b0;
                alu_op    = funct3_to_op(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) inst_class = CLS_OPIMM;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) inst_class = CLS_OPIMM;
                end else begin
                    inst_class = CLS_OPIMM;
                end
            end
            OPC_LOAD: begin
                alu_sel_2 = 1'b0;
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
                    inst_class = CLS_LOAD;
            end
            OPC_STORE: begin
                alu_sel_2 = 1'b0;
                if (!funct3[2] && funct3 != 3'b011) inst_class = CLS_STORE;
            end
            OPC_BRANCH: begin
                alu_op = SUB;
                if (funct3 != 3'b010 && funct3 != 3'b011) inst_class = CLS_BRANCH;
            end
            OPC_JAL: begin
                alu_sel_1  = 1'b0;
                alu_sel_2  = 1'b0;
                inst_class = CLS_JAL;
            end
            OPC_JALR: begin
                alu_sel_2 = 1'b0;
                if (funct3 == 3'b000) inst_class = CLS_JALR;
            end
            OPC_LUI: begin
                alu_op     = PASS_B;
                alu_sel_1  = 1'b0;
                alu_sel_2  = 1'b0;
                inst_class = CLS_LUI;
            end
            OPC_AUIPC: begin
                alu_sel_1  = 1'b0;
                alu_sel_2  = 1'b0;
                inst_class = CLS_AUIPC;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zeros;
            3'b001:  branch_taken = !zeros;
            3'b100:  branch_taken = flag_lt;
            3'b101:  branch_taken = !flag_lt;
            3'b110:  branch_taken = flag_ltu;
            3'b111:  branch_taken = !flag_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with bus-wait timeout; define CU_TRAP_EN to halt on illegal
// instructions instead of executing them as NOPs.
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int XLEN    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        zeros,
    input  logic        flag_lt,
    input  logic        flag_ltu,
    output operator_t   alu_op_select,
    output logic        alu_scr_sel_1,
    output logic        alu_scr_sel_2,
    output logic        ir_load,
    output logic        reg_write,
    output logic        pc_write,
    output logic [1:0]  PC_select,
    output logic [1:0]  write_from,
    output logic        illegal,
    output logic        bus_fault,
    output logic [2:0]  state
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("multicycle_control_unit: TIMEOUT must be 1..65535");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("multicycle_control_unit: XLEN must be 32 or 64");
    end

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d, wait_inc;
    logic        illegal_q, illegal_d;
    logic        bus_fault_q, bus_fault_d;
    logic        stalled;

    inst_class_t dec_class;
    logic        dec_taken;
    logic        dec_rd_zero;
    logic        dec_illegal;

    instr_decoder u_decoder (
        .inst         (inst),
        .zeros        (zeros),
        .flag_lt      (flag_lt),
        .flag_ltu     (flag_ltu),
        .alu_op       (alu_op_select),
        .alu_sel_1    (alu_scr_sel_1),
        .alu_sel_2    (alu_scr_sel_2),
        .inst_class   (dec_class),
        .branch_taken (dec_taken),
        .rd_zero      (dec_rd_zero),
        .illegal      (dec_illegal)
    );

    assign wait_inc  = wait_q + 16'd1;
    assign illegal   = illegal_q;
    assign bus_fault = bus_fault_q;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_fault_q <= bus_fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_fault_d = bus_fault_q;
        stalled     = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_load     = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        PC_select   = PC_PLUS4;
        write_from  = WB_ALU;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end else if (wait_inc == TimeoutCnt) begin
                    state_d     = HALT;
                    bus_fault_d = 1'b1;
                end else begin
                    stalled = 1'b1;
                end
            end
            DECODE: begin
`ifdef CU_TRAP_EN
                if (dec_illegal) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXECUTE;
                end
`else
                state_d = EXECUTE;
`endif
            end
            EXECUTE: begin
                case (dec_class)
                    CLS_R, CLS_OPIMM, CLS_LUI, CLS_AUIPC: state_d = WRITEBACK;
                    CLS_LOAD, CLS_STORE:                  state_d = MEM;
                    CLS_BRANCH: begin
                        pc_write  = 1'b1;
                        PC_select = dec_taken ? PC_TARGET : PC_PLUS4;
                        state_d   = FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        reg_write  = !dec_rd_zero;
                        write_from = WB_PC4;
                        pc_write   = 1'b1;
                        PC_select  = (dec_class == CLS_JAL) ? PC_TARGET : PC_JALR;
                        state_d    = FETCH;
                    end
                    default: begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_class == CLS_STORE);
                if (dmem_ack) begin
                    if (dec_class == CLS_STORE) begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (wait_inc == TimeoutCnt) begin
                    state_d     = HALT;
                    bus_fault_d = 1'b1;
                end else begin
                    stalled = 1'b1;
                end
            end
            WRITEBACK: begin
                reg_write  = !dec_rd_zero;
                pc_write   = 1'b1;
                write_from = (dec_class == CLS_LOAD) ? WB_MEM : WB_ALU;
                state_d    = FETCH;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase

        // Any transition restarts the bus-wait count, including the one into HALT
        if (state_d != state_q) wait_d = '0;
        else if (stalled)       wait_d = wait_inc;
        else                    wait_d = wait_q;

        // An instruction interrupted by reset must not commit anything
        if (rst) begin
            ir_load   = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed scenarios plus random instruction streams against a
// per-instruction expected-cycle model.
module tb_multicycle_control_unit;
    import riscv_pkg::*;

    localparam int TimeoutCycles = 4;
    localparam int K_R = 0, K_OPIMM = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        zeros = 1'b0, flag_lt = 1'b0, flag_ltu = 1'b0;
    logic        imem_req, dmem_req, dmem_we;
    operator_t   alu_op_select;
    logic        alu_scr_sel_1, alu_scr_sel_2;
    logic        ir_load, reg_write, pc_write;
    logic [1:0]  PC_select, write_from;
    logic        illegal, bus_fault;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] st;
        logic       imemReq, dmemReq, dmemWe, irLoad, regWrite, pcWrite;
        logic [1:0] pcSel, wFrom;
        logic       chkW, chkAlu, chkSel1;
        logic [3:0] aluOp;
        logic       sel1, sel2;
        logic       imemAck, dmemAck;
    } exp_t;

    exp_t expQ[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.TIMEOUT(TimeoutCycles), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .inst(inst),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .zeros(zeros), .flag_lt(flag_lt), .flag_ltu(flag_ltu),
        .alu_op_select(alu_op_select),
        .alu_scr_sel_1(alu_scr_sel_1), .alu_scr_sel_2(alu_scr_sel_2),
        .ir_load(ir_load), .reg_write(reg_write), .pc_write(pc_write),
        .PC_select(PC_select), .write_from(write_from),
        .illegal(illegal), .bus_fault(bus_fault), .state(state)
    );

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkVec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkInst(input logic [6:0] f7, input logic [9:0] mid,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {f7, mid, f3, rd, op};
    endfunction

    function automatic exp_t blank(input logic [2:0] s);
        exp_t e;
        e = '{st: s, imemReq: 1'b0, dmemReq: 1'b0, dmemWe: 1'b0, irLoad: 1'b0,
              regWrite: 1'b0, pcWrite: 1'b0, pcSel: 2'b00, wFrom: 2'b00,
              chkW: 1'b0, chkAlu: 1'b0, chkSel1: 1'b0, aluOp: 4'h0,
              sel1: 1'b0, sel2: 1'b0, imemAck: 1'b0, dmemAck: 1'b0};
        return e;
    endfunction

    function automatic logic [3:0] expAluOp(input int kind, input logic [2:0] f3,
                                            input logic [6:0] f7);
        operator_t opTable [8];
        operator_t op;
        opTable = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        op = opTable[f3];
        if (kind == K_R && op == ADD && f7[5]) op = SUB;
        if (op == SRL && f7[5]) op = SRA;
        if (kind == K_LUI) op = PASS_B;
        if (kind == K_AUIPC || kind == K_LOAD || kind == K_STORE) op = ADD;
        return 4'(op);
    endfunction

    function automatic logic expTaken(input logic [2:0] f3);
        case (f3)
            3'd0:    return zeros;
            3'd1:    return !zeros;
            3'd4:    return flag_lt;
            3'd5:    return !flag_lt;
            3'd6:    return flag_ltu;
            default: return !flag_ltu;
        endcase
    endfunction

    task automatic buildTrace(input logic [31:0] ins, input int kind, input int imemDelay,
                              input int dmemDelay);
        exp_t e;
        logic rdLive;
        rdLive = (ins[11:7] != 5'd0);
        for (int i = 0; i < imemDelay; i++) begin
            e = blank(FETCH); e.imemReq = 1'b1; expQ.push_back(e);
        end
        e = blank(FETCH); e.imemReq = 1'b1; e.imemAck = 1'b1; e.irLoad = 1'b1;
        expQ.push_back(e);
        expQ.push_back(blank(DECODE));
        e = blank(EXECUTE);
        if (kind inside {K_R, K_OPIMM, K_LUI, K_AUIPC, K_LOAD, K_STORE}) begin
            e.chkAlu  = 1'b1;
            e.aluOp   = expAluOp(kind, ins[14:12], ins[31:25]);
            e.chkSel1 = (kind != K_LUI);
            e.sel1    = !(kind == K_AUIPC);
            e.sel2    = (kind == K_R);
        end
        case (kind)
            K_R, K_OPIMM, K_LUI, K_AUIPC: begin
                expQ.push_back(e);
                e = blank(WRITEBACK); e.regWrite = rdLive; e.pcWrite = 1'b1;
                e.chkW = 1'b1; e.wFrom = WB_ALU; expQ.push_back(e);
            end
            K_LOAD, K_STORE: begin
                expQ.push_back(e);
                for (int i = 0; i <= dmemDelay; i++) begin
                    e = blank(MEM); e.dmemReq = 1'b1; e.dmemWe = (kind == K_STORE);
                    if (i == dmemDelay) begin
                        e.dmemAck = 1'b1;
                        e.pcWrite = (kind == K_STORE);
                    end
                    expQ.push_back(e);
                end
                if (kind == K_LOAD) begin
                    e = blank(WRITEBACK); e.regWrite = rdLive; e.pcWrite = 1'b1;
                    e.chkW = 1'b1; e.wFrom = WB_MEM; expQ.push_back(e);
                end
            end
            K_BRANCH: begin
                e.pcWrite = 1'b1; e.pcSel = expTaken(ins[14:12]) ? PC_TARGET : PC_PLUS4;
                expQ.push_back(e);
            end
            K_JAL, K_JALR: begin
                e.regWrite = rdLive; e.chkW = 1'b1; e.wFrom = WB_PC4; e.pcWrite = 1'b1;
                e.pcSel = (kind == K_JAL) ? PC_TARGET : PC_JALR;
                expQ.push_back(e);
            end
            default: begin
                e.pcWrite = 1'b1; e.pcSel = PC_PLUS4; expQ.push_back(e);
            end
        endcase
    endtask

    task automatic playTrace(input int n);
        exp_t e;
        int   cnt = 0;
        while (expQ.size() > 0 && (n < 0 || cnt < n)) begin
            e = expQ.pop_front();
            cnt++;
            imem_ack = e.imemAck;
            dmem_ack = e.dmemAck;
            #1;
            checkVec("state", 4'(state), 4'(e.st));
            checkBit("imem_req", imem_req, e.imemReq);
            checkBit("dmem_req", dmem_req, e.dmemReq);
            if (e.dmemReq) checkBit("dmem_we", dmem_we, e.dmemWe);
            checkBit("ir_load", ir_load, e.irLoad);
            checkBit("reg_write", reg_write, e.regWrite);
            checkBit("pc_write", pc_write, e.pcWrite);
            if (e.pcWrite) checkVec("PC_select", 4'(PC_select), 4'(e.pcSel));
            if (e.chkW) checkVec("write_from", 4'(write_from), 4'(e.wFrom));
            if (e.chkAlu) begin
                checkVec("alu_op", 4'(alu_op_select), e.aluOp);
                checkBit("alu_sel_2", alu_scr_sel_2, e.sel2);
                if (e.chkSel1) checkBit("alu_sel_1", alu_scr_sel_1, e.sel1);
            end
            checkBit("bus_fault", bus_fault, 1'b0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input int kind, input int id,
                                 input int dd);
        inst = ins;
        buildTrace(ins, kind, id, dd);
        playTrace(-1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic genInst(output logic [31:0] ins, output int kind);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [9:0]  mid;
        logic [19:0] upper;
        int          idx;
        kind  = $urandom_range(0, 8);
        f7    = 7'($urandom);
        f3    = 3'($urandom);
        mid   = 10'($urandom);
        upper = 20'($urandom);
        rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        case (kind)
            K_R: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                ins = mkInst(f7, mid, f3, rd, OPC_R);
            end
            K_OPIMM: begin
                if (f3 == 3'd1) f7 = 7'h00;
                else if (f3 == 3'd5) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                ins = mkInst(f7, mid, f3, rd, OPC_OPIMM);
            end
            K_LOAD: begin
                idx = $urandom_range(0, 4);
                ins = mkInst(f7, mid, (idx < 3) ? 3'(idx) : 3'(idx + 1), rd, OPC_LOAD);
            end
            K_STORE:  ins = mkInst(f7, mid, 3'($urandom_range(0, 2)), rd, OPC_STORE);
            K_BRANCH: begin
                idx = $urandom_range(0, 5);
                ins = mkInst(f7, mid, (idx < 2) ? 3'(idx) : 3'(idx + 2), rd, OPC_BRANCH);
            end
            K_JALR:  ins = mkInst(f7, mid, 3'd0, rd, OPC_JALR);
            K_JAL:   ins = {upper, rd, OPC_JAL};
            K_LUI:   ins = {upper, rd, OPC_LUI};
            default: ins = {upper, rd, OPC_AUIPC};
        endcase
    endtask

    initial begin
        logic [31:0] ins;
        int          kind;

        doReset();
        #1;
        checkVec("rst_state", 4'(state), 4'(FETCH));
        checkBit("rst_imem_req", imem_req, 1'b1);
        checkBit("rst_dmem_req", dmem_req, 1'b0);
        checkBit("rst_reg_write", reg_write, 1'b0);
        checkBit("rst_pc_write", pc_write, 1'b0);
        checkBit("rst_illegal", illegal, 1'b0);
        checkBit("rst_bus_fault", bus_fault, 1'b0);

        // ADD x3,x1,x2 with immediate fetch ack
        applyStimulus(mkInst(7'h00, {5'd2, 5'd1}, 3'b000, 5'd3, OPC_R), K_R, 0, 0);

        // BLT taken and not taken
        flag_lt = 1'b1;
        applyStimulus(mkInst(7'h00, {5'd2, 5'd1}, 3'b100, 5'd8, OPC_BRANCH), K_BRANCH, 0, 0);
        flag_lt = 1'b0;
        applyStimulus(mkInst(7'h00, {5'd2, 5'd1}, 3'b100, 5'd8, OPC_BRANCH), K_BRANCH, 1, 0);

        // LW with data ack three cycles late, landing on the timeout boundary
        applyStimulus(mkInst(7'h00, {5'd0, 5'd1}, 3'b010, 5'd5, OPC_LOAD), K_LOAD, 0, 3);
        applyStimulus(mkInst(7'h00, {5'd2, 5'd1}, 3'b010, 5'd4, OPC_STORE), K_STORE, 3, 1);

        // Illegal opcode
        ins  = mkInst(7'h00, 10'h0, 3'b000, 5'd3, 7'b1111111);
        inst = ins;
`ifdef CU_TRAP_EN
        buildTrace(ins, K_ILL, 0, 0);
        playTrace(2);
        expQ.delete();
        #1;
        checkVec("trap_state", 4'(state), 4'(HALT));
        checkBit("trap_illegal", illegal, 1'b1);
        checkBit("trap_imem_req", imem_req, 1'b0);
        checkBit("trap_reg_write", reg_write, 1'b0);
        doReset();
`else
        applyStimulus(ins, K_ILL, 0, 0);
        #1;
        checkVec("nop_next_state", 4'(state), 4'(FETCH));
        checkBit("nop_illegal", illegal, 1'b0);
`endif

        for (int n = 0; n < 80; n++) begin
            genInst(ins, kind);
            zeros    = 1'($urandom);
            flag_lt  = 1'($urandom);
            flag_ltu = 1'($urandom);
            applyStimulus(ins, kind, $urandom_range(0, TimeoutCycles - 1),
                          $urandom_range(0, TimeoutCycles - 1));
        end

        // Reset pulsed while a load waits in MEM
        inst = mkInst(7'h00, {5'd0, 5'd1}, 3'b010, 5'd6, OPC_LOAD);
        buildTrace(inst, K_LOAD, 0, 3);
        playTrace(3);
        expQ.delete();
        dmem_ack = 1'b0;
        #1;
        checkVec("mem_state", 4'(state), 4'(MEM));
        checkBit("mem_dmem_req", dmem_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkBit("rstmem_dmem_req", dmem_req, 1'b0);
        checkVec("rstmem_state", 4'(state), 4'(FETCH));
        checkBit("rstmem_reg_write", reg_write, 1'b0);
        checkBit("rstmem_pc_write", pc_write, 1'b0);
        rst = 1'b0;

        // Fetch timeout with ack never arriving
        doReset();
        for (int i = 0; i < TimeoutCycles; i++) begin
            imem_ack = 1'b0;
            #1;
            checkVec("to_fetch_state", 4'(state), 4'(FETCH));
            checkBit("to_fetch_imem_req", imem_req, 1'b1);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            #1;
            checkVec("to_halt_state", 4'(state), 4'(HALT));
            checkBit("to_bus_fault", bus_fault, 1'b1);
            checkBit("to_imem_req", imem_req, 1'b0);
            checkBit("to_ir_load", ir_load, 1'b0);
            checkBit("to_pc_write", pc_write, 1'b0);
            checkBit("to_reg_write", reg_write, 1'b0);
            @(negedge clk);
        end
        imem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
